dcache_port_arbiter: RTL
========================

Name: dcache_port_arbiter

Overview:
- Owns the single dcache request port and shares it between two requesters: the EX1 pipeline load/store path and the privileged CACOP-D path.
- Registers each granted request and holds it on the cache interface until the cache handshakes.
- Returns a completion pulse (with load data) to the winning requester.
- Tracks pipeline flushes so a killed load/store still drains on the cache side but is never reported back. A watchdog flags hung transactions.

Parameters:
- TIMEOUT, 1024: cycles a single transaction may stay outstanding before err_timeout sets.
- CW, 11: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  pipeline flush (branch mispredict / ertn / exception)
- pipe_valid  in  1  pipeline mem request, held until pipe_grant
- pipe_op  in  1  0 = read, 1 = write
- pipe_wstrb  in  4  write type: 0001 byte, 0011 half, 1111 word
- pipe_addr  in  32  address
- pipe_wdata  in  32  store data
- pipe_atom  in  1  atomic (LL/SC) marker
- pipe_grant  out  1  combinational accept pulse
- pipe_done  out  1  registered one-cycle completion pulse
- pipe_rdata  out  32  load data, valid with pipe_done
- cacop_valid  in  1  CACOP-D request, held until cacop_grant
- cacop_type  in  2  cacop code
- cacop_vaddr  in  32  cacop address
- cacop_grant  out  1  combinational accept pulse
- cacop_done_o  out  1  registered completion pulse
- dc_rvalid  out  1  read request to dcache
- dc_wvalid  out  1  write request to dcache
- dc_op  out  1  0 read, 1 write
- dc_wstrb  out  4  byte strobe (0000 on reads)
- dc_addr  out  32  address
- dc_wdata  out  32  write data
- dc_atom  out  1  atomic marker
- dc_rready  in  1  read accepted; dc_rdata valid the same cycle
- dc_rdata  in  32  read data
- dc_wready  in  1  write accepted
- dc_cacop_en  out  1  cacop request to dcache
- dc_cacop_type  out  2  cacop code
- dc_cacop_vaddr  out  32  cacop address
- dc_cacop_ready  in  1  cacop accepted
- dc_cacop_done  in  1  cacop finished
- err_timeout  out  1  sticky watchdog flag
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, kill = 0, wdog = 0, last_pipe = 1 (first tie goes to cacop).
- States:
  - IDLE
  - MEM: dc_rvalid/dc_wvalid held from registered fields.
  - CREQ: dc_cacop_en held.
  - CWAIT: waiting for dc_cacop_done.
- Arbitration (IDLE only):
  - pipe_grant = pipe_valid & ~flush & (~cacop_valid | last_pipe == 0).
  - cacop_grant = cacop_valid & ~pipe_grant.
  - A tie alternates through last_pipe, which updates on every grant.
  - flush does not block a cacop grant.
- Grant captures the request fields; the next state is MEM or CREQ. Cache-side outputs are registered, so the first dc_*valid appears the cycle after grant.
- MEM: the request is held unchanged until (dc_op = 0 & dc_rready) or (dc_op = 1 & dc_wready). The cycle after the handshake:
  - pipe_done = ~kill.
  - pipe_rdata = captured dc_rdata (0 for writes).
  - State returns to IDLE; kill clears.
  - Minimum pipe_valid-to-pipe_done latency is 2 cycles.
- flush in MEM: sets kill. The request is never withdrawn mid-handshake, so it completes on the cache side and pipe_done is suppressed. A flush on the handshake cycle itself also suppresses.
- CREQ: dc_cacop_en held until dc_cacop_ready, then CWAIT.
  - dc_cacop_done in CWAIT deasserts, then cacop_done_o pulses next cycle and state returns to IDLE.
  - ready and done in the same cycle (in CREQ) go straight to the done pulse.
  - flush does not affect cacop.
- Back-to-back: a new grant is legal in the same cycle pipe_done/cacop_done_o pulses (state is already IDLE).
- Watchdog: wdog clears on entering MEM/CREQ and increments each non-IDLE cycle. When it reaches TIMEOUT, err_timeout sets (sticky until rst) and wdog saturates. The transaction keeps waiting.
- rst mid-transaction: immediate return to reset values; no done pulses; cache outputs drop asynchronously.

Test Plan:
- Load: pipe_valid, op = 0, addr = 0x1C000100; dc_rready high at first dc_rvalid with dc_rdata = 0xDEADBEEF -> pipe_grant@T, dc_rvalid@T+1, pipe_done with pipe_rdata = 0xDEADBEEF @T+2.
- Store byte, wstrb = 0001, dc_wready delayed 3 cycles -> dc_wvalid/addr/wdata stable for 4 cycles, single pipe_done, pipe_rdata = 0.
- pipe_valid and cacop_valid together after reset -> cacop granted first; pipe granted the cycle cacop_done_o pulses; a second simultaneous tie then goes to cacop again only after a pipe grant.
- flush one cycle after a load grant, dc_rready 2 cycles later -> handshake completes, no pipe_done, busy low after, next grant accepted.
- TIMEOUT = 8, dc_cacop_ready never asserts -> err_timeout high after 8 cycles in CREQ, stays high; rst clears all outputs to 0.
- flush with pipe_valid in IDLE -> no pipe_grant that cycle; grant the next cycle if flush is low.

Source files
------------

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of every signal between the dcache port arbiter, its two requesters and the dcache.
// The master modport is the arbiter's view; slave is the surrounding pipeline/cache view.
interface dcache_port_arbiter_if;
   logic        flush;
   logic        pipe_valid;
   logic        pipe_op;
   logic [3:0]  pipe_wstrb;
   logic [31:0] pipe_addr;
   logic [31:0] pipe_wdata;
   logic        pipe_atom;
   logic        pipe_grant;
   logic        pipe_done;
   logic [31:0] pipe_rdata;
   logic        cacop_valid;
   logic [1:0]  cacop_type;
   logic [31:0] cacop_vaddr;
   logic        cacop_grant;
   logic        cacop_done_o;
   logic        dc_rvalid;
   logic        dc_wvalid;
   logic        dc_op;
   logic [3:0]  dc_wstrb;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic        dc_atom;
   logic        dc_rready;
   logic [31:0] dc_rdata;
   logic        dc_wready;
   logic        dc_cacop_en;
   logic [1:0]  dc_cacop_type;
   logic [31:0] dc_cacop_vaddr;
   logic        dc_cacop_ready;
   logic        dc_cacop_done;
   logic        err_timeout;
   logic        busy;

   modport master (
      input  flush, pipe_valid, pipe_op, pipe_wstrb, pipe_addr, pipe_wdata, pipe_atom,
      output pipe_grant, pipe_done, pipe_rdata,
      input  cacop_valid, cacop_type, cacop_vaddr,
      output cacop_grant, cacop_done_o,
      output dc_rvalid, dc_wvalid, dc_op, dc_wstrb, dc_addr, dc_wdata, dc_atom,
      input  dc_rready, dc_rdata, dc_wready,
      output dc_cacop_en, dc_cacop_type, dc_cacop_vaddr,
      input  dc_cacop_ready, dc_cacop_done,
      output err_timeout, busy
   );

   modport slave (
      output flush, pipe_valid, pipe_op, pipe_wstrb, pipe_addr, pipe_wdata, pipe_atom,
      input  pipe_grant, pipe_done, pipe_rdata,
      output cacop_valid, cacop_type, cacop_vaddr,
      input  cacop_grant, cacop_done_o,
      input  dc_rvalid, dc_wvalid, dc_op, dc_wstrb, dc_addr, dc_wdata, dc_atom,
      output dc_rready, dc_rdata, dc_wready,
      input  dc_cacop_en, dc_cacop_type, dc_cacop_vaddr,
      output dc_cacop_ready, dc_cacop_done,
      input  err_timeout, busy
   );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache request port between the EX1 load/store path and CACOP-D,
// holding each granted request until the cache handshakes and reporting completion back.
module dcache_port_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CW      = 11
) (
   input logic                  clk,
   input logic                  rst,
   dcache_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, MEM, CREQ, CWAIT} state_t;

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t      state, state_nxt;
   logic        kill, last_pipe, err_q;
   logic        pipe_done_q, cacop_done_q;
   logic [31:0] pipe_rdata_q;
   logic        op_q, atom_q;
   logic [3:0]  wstrb_q;
   logic [31:0] addr_q, wdata_q, cvaddr_q;
   logic [1:0]  ctype_q;
   logic [CW-1:0] wdog;
   logic        idle, pipe_grant, cacop_grant, mem_hs, cacop_fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // On a tie last_pipe hands the port to whichever side did not win last time.
   always_comb begin
      state_nxt   = state;
      idle        = (state == IDLE);
      pipe_grant  = idle & bus.pipe_valid & ~bus.flush & (~bus.cacop_valid | ~last_pipe);
      cacop_grant = idle & bus.cacop_valid & ~pipe_grant;
      mem_hs      = (state == MEM) & ((~op_q & bus.dc_rready) | (op_q & bus.dc_wready));
      cacop_fin   = ((state == CREQ) & bus.dc_cacop_ready & bus.dc_cacop_done) |
                    ((state == CWAIT) & bus.dc_cacop_done);
      case (state)
         IDLE: begin
            if (pipe_grant)       state_nxt = MEM;
            else if (cacop_grant) state_nxt = CREQ;
         end
         MEM:   if (mem_hs) state_nxt = IDLE;
         CREQ: begin
            if (bus.dc_cacop_ready) state_nxt = bus.dc_cacop_done ? IDLE : CWAIT;
         end
         CWAIT: if (bus.dc_cacop_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A flushed access still completes at the cache; kill only hides its completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kill         <= 1'b0;
         last_pipe    <= 1'b1;
         err_q        <= 1'b0;
         pipe_done_q  <= 1'b0;
         cacop_done_q <= 1'b0;
         pipe_rdata_q <= '0;
         op_q         <= 1'b0;
         atom_q       <= 1'b0;
         wstrb_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cvaddr_q     <= '0;
         ctype_q      <= '0;
         wdog         <= '0;
      end else begin
         pipe_done_q  <= 1'b0;
         cacop_done_q <= cacop_fin;
         if (pipe_grant) begin
            op_q      <= bus.pipe_op;
            wstrb_q   <= bus.pipe_op ? bus.pipe_wstrb : 4'b0000;
            addr_q    <= bus.pipe_addr;
            wdata_q   <= bus.pipe_wdata;
            atom_q    <= bus.pipe_atom;
            last_pipe <= 1'b1;
            kill      <= 1'b0;
         end
         if (cacop_grant) begin
            ctype_q   <= bus.cacop_type;
            cvaddr_q  <= bus.cacop_vaddr;
            last_pipe <= 1'b0;
         end
         if (mem_hs) begin
            pipe_done_q  <= ~kill & ~bus.flush;
            pipe_rdata_q <= op_q ? 32'h0 : bus.dc_rdata;
            kill         <= 1'b0;
         end else if ((state == MEM) && bus.flush) begin
            kill <= 1'b1;
         end
         if (pipe_grant || cacop_grant) begin
            wdog <= '0;
         end else if (!idle && (wdog != TMO)) begin
            wdog <= wdog + CW'(1);
            if (wdog == TMO - CW'(1)) err_q <= 1'b1;
         end
      end
   end

   assign bus.pipe_grant     = pipe_grant;
   assign bus.cacop_grant    = cacop_grant;
   assign bus.pipe_done      = pipe_done_q;
   assign bus.pipe_rdata     = pipe_rdata_q;
   assign bus.cacop_done_o   = cacop_done_q;
   assign bus.dc_rvalid      = (state == MEM) & ~op_q;
   assign bus.dc_wvalid      = (state == MEM) & op_q;
   assign bus.dc_op          = op_q;
   assign bus.dc_wstrb       = wstrb_q;
   assign bus.dc_addr        = addr_q;
   assign bus.dc_wdata       = wdata_q;
   assign bus.dc_atom        = atom_q;
   assign bus.dc_cacop_en    = (state == CREQ);
   assign bus.dc_cacop_type  = ctype_q;
   assign bus.dc_cacop_vaddr = cvaddr_q;
   assign bus.err_timeout    = err_q;
   assign bus.busy           = ~idle;

endmodule
